// File: rtl/fake7501_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fake7501_pkg                                                         |
// | Shared state type and default timing constants for the phi sequencer |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package fake7501_pkg;

    typedef enum logic [1:0] {
        SYNC       = 2'd0,
        LOW        = 2'd1,
        HIGH_GATED = 2'd2,
        HIGH_HELD  = 2'd3
    } seq_state_t;

    localparam int SEQ_SYNC_STAGES = 2;
    localparam int SEQ_FILTER      = 2;
    localparam int SEQ_GATE_DELAY  = 3;
    localparam int SEQ_TIMEOUT     = 1024;

endpackage
`default_nettype wire

// File: rtl/phi_filter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | phi_filter                                                           |
// | Synchronizer plus run-length glitch filter with edge pulses          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module phi_filter
    import fake7501_pkg::*;
#(
    parameter int SYNC_STAGES = SEQ_SYNC_STAGES,
    parameter int FILTER      = SEQ_FILTER
) (
    input  logic clock,
    input  logic reset,
    input  logic sig_in,
    output logic pf,
    output logic rise,
    output logic fall
);

    localparam int CW = (FILTER > 1) ? $clog2(FILTER) : 1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic                   r_pf;
    logic                   r_pf_d;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_sync;

    assign w_sync = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync <= '0;
            r_cnt  <= '0;
            r_pf   <= 1'b0;
            r_pf_d <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
            if (w_sync == r_pf) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(FILTER - 1)) begin
                r_pf  <= w_sync;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
            // Pulses are taken one tick after pf moves so both edges share one latency
            r_pf_d <= r_pf;
            r_rise <= r_pf & ~r_pf_d;
            r_fall <= ~r_pf & r_pf_d;
        end
    end

    assign pf   = r_pf;
    assign rise = r_rise;
    assign fall = r_fall;

endmodule
`default_nettype wire

// File: rtl/phi_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | phi_sequencer                                                        |
// | Derives phi2, R/W gate and AEC qualifier from the TED phi0 and AEC   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module phi_sequencer
    import fake7501_pkg::*;
#(
    parameter int SYNC_STAGES = SEQ_SYNC_STAGES,
    parameter int FILTER      = SEQ_FILTER,
    parameter int GATE_DELAY  = SEQ_GATE_DELAY,
    parameter int TIMEOUT     = SEQ_TIMEOUT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       phi0_in,
    input  logic       aec_in,
    output logic       phi2,
    output logic       gate,
    output logic       aec_out,
    output logic       cycle_end,
    output logic [7:0] high_ticks,
    output logic       stalled
);

    localparam int WD_W = $clog2(TIMEOUT) + 1;

    seq_state_t             r_state;
    logic [SYNC_STAGES-1:0] r_aec_sync;
    logic [7:0]             r_phase;
    logic [WD_W-1:0]        r_wd;
    logic                   w_pf_unused;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_timeout;
    logic                   w_gate_hit;
    logic [7:0]             w_phase_inc;

    phi_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILTER     (FILTER)
    ) u_phi_filter (
        .clock (clock),
        .reset (reset),
        .sig_in(phi0_in),
        .pf    (w_pf_unused),
        .rise  (w_rise),
        .fall  (w_fall)
    );

    assign w_phase_inc = (r_phase == 8'hFF) ? r_phase : r_phase + 8'd1;
    assign w_gate_hit  = ({24'd0, r_phase} == 32'(GATE_DELAY - 1));
    assign w_timeout   = (r_wd == WD_W'(TIMEOUT - 1)) && !w_rise && !w_fall;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= SYNC;
            r_aec_sync <= '0;
            r_phase    <= 8'd0;
            r_wd       <= '0;
            phi2       <= 1'b0;
            gate       <= 1'b1;
            aec_out    <= 1'b0;
            cycle_end  <= 1'b0;
            high_ticks <= 8'd0;
            stalled    <= 1'b0;
        end else begin
            r_aec_sync <= {r_aec_sync[SYNC_STAGES-2:0], aec_in};
            cycle_end  <= 1'b0;

            if (r_state == SYNC || w_rise || w_fall) begin
                r_wd <= '0;
            end else begin
                r_wd <= r_wd + WD_W'(1);
            end

            if (r_state != SYNC && w_timeout) begin
                r_state <= SYNC;
                phi2    <= 1'b0;
                gate    <= 1'b1;
                aec_out <= 1'b0;
                stalled <= 1'b1;
            end else begin
                case (r_state)
                    SYNC: begin
                        if (w_fall) begin
                            r_state <= LOW;
                        end
                    end
                    LOW: begin
                        if (w_rise) begin
                            r_state <= HIGH_GATED;
                            phi2    <= 1'b1;
                            aec_out <= r_aec_sync[SYNC_STAGES-1];
                            r_phase <= 8'd0;
                        end
                    end
                    HIGH_GATED, HIGH_HELD: begin
                        r_phase <= w_phase_inc;
                        // A fall on the gate-match tick wins, so gate never glitches low
                        if (w_fall) begin
                            r_state    <= LOW;
                            phi2       <= 1'b0;
                            gate       <= 1'b1;
                            cycle_end  <= 1'b1;
                            high_ticks <= w_phase_inc;
                        end else if (r_state == HIGH_GATED && w_gate_hit) begin
                            r_state <= HIGH_HELD;
                            gate    <= 1'b0;
                        end
                    end
                    default: r_state <= SYNC;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_phi_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_phi_sequencer                                                     |
// | Vector table, directed corner cases and random phi0/AEC vs a model   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_phi_sequencer;
    import fake7501_pkg::*;

    localparam int S  = SEQ_SYNC_STAGES;
    localparam int F  = SEQ_FILTER;
    localparam int GD = SEQ_GATE_DELAY;
    localparam int TO = SEQ_TIMEOUT;

    logic       clock = 1'b0;
    logic       reset;
    logic       phi0_in;
    logic       aec_in;
    logic       phi2;
    logic       gate;
    logic       aec_out;
    logic       cycle_end;
    logic [7:0] high_ticks;
    logic       stalled;

    always #5 clock = ~clock;

    phi_sequencer #(
        .SYNC_STAGES(S),
        .FILTER     (F),
        .GATE_DELAY (GD),
        .TIMEOUT    (TO)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .phi0_in   (phi0_in),
        .aec_in    (aec_in),
        .phi2      (phi2),
        .gate      (gate),
        .aec_out   (aec_out),
        .cycle_end (cycle_end),
        .high_ticks(high_ticks),
        .stalled   (stalled)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: input history delays, run-length filter, phase bookkeeping
    bit m_phq[$];
    bit m_aq[$];
    int m_evq[$];
    bit m_pf, m_in_sync, m_phi2, m_aec, m_stalled, m_ce;
    int m_run, m_since, m_quiet, m_ht;

    int gate_low_cnt, ce_cnt, phi2_hi_cnt;

    typedef struct {
        int hi;
        int lo;
        bit aec;
        int exp_ht;
        int exp_gate_low;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phq.delete();
        m_aq.delete();
        m_evq.delete();
        for (int i = 0; i < S; i++) begin
            m_phq.push_back(1'b0);
            m_aq.push_back(1'b0);
        end
        m_evq.push_back(0);
        m_evq.push_back(0);
        m_pf = 0; m_run = 0; m_in_sync = 1; m_phi2 = 0; m_aec = 0;
        m_stalled = 0; m_ce = 0; m_since = 0; m_quiet = 0; m_ht = 0;
    endtask

    task automatic model_edge(input bit v, input bit a);
        bit s, sa;
        int e, ev;
        s  = m_phq.pop_front(); m_phq.push_back(v);
        sa = m_aq.pop_front();  m_aq.push_back(a);
        ev = 0;
        if (s != m_pf) begin
            m_run++;
            if (m_run >= F) begin
                m_pf  = s;
                m_run = 0;
                ev    = s ? 1 : -1;
            end
        end else begin
            m_run = 0;
        end
        e = m_evq.pop_front();
        m_evq.push_back(ev);
        m_ce = 0;
        if (e != 0 || m_in_sync) m_quiet = 0;
        else m_quiet++;
        if (!m_in_sync && m_quiet >= TO) begin
            m_in_sync = 1; m_phi2 = 0; m_aec = 0; m_stalled = 1; m_quiet = 0;
        end else if (m_in_sync) begin
            if (e < 0) m_in_sync = 0;
        end else if (!m_phi2) begin
            if (e > 0) begin
                m_phi2 = 1; m_since = 0; m_aec = sa;
            end
        end else if (e < 0) begin
            m_phi2 = 0;
            m_ce   = 1;
            m_ht   = (m_since + 1 > 255) ? 255 : m_since + 1;
        end else begin
            m_since++;
        end
    endtask

    function automatic logic [12:0] dut_outs();
        return {phi2, gate, aec_out, cycle_end, high_ticks, stalled};
    endfunction

    function automatic logic [12:0] model_outs();
        bit g;
        g = !(m_phi2 && m_since >= GD);
        return {m_phi2, g, m_aec, m_ce, 8'(m_ht), m_stalled};
    endfunction

    task automatic step();
        @(posedge clock);
        if (reset) model_reset();
        else model_edge(phi0_in, aec_in);
        #1;
        check("outs_vs_model", 32'(dut_outs()), 32'(model_outs()));
        if (!gate) gate_low_cnt++;
        if (cycle_end) ce_cnt++;
        if (phi2) phi2_hi_cnt++;
    endtask

    task automatic drive_level(input bit lvl, input int n);
        phi0_in = lvl;
        repeat (n) step();
    endtask

    task automatic clear_counts();
        gate_low_cnt = 0; ce_cnt = 0; phi2_hi_cnt = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL sim_timeout: simulation exceeded time bound");
        $fatal(1, "time bound expired");
    end

    initial begin
        int rise_at, fall_at, gate_mid, stall_pre;

        vecs[0] = '{hi: 8,  lo: 8,  aec: 1'b1, exp_ht: 8,  exp_gate_low: 5};
        vecs[1] = '{hi: 2,  lo: 14, aec: 1'b1, exp_ht: 2,  exp_gate_low: 0};
        vecs[2] = '{hi: 3,  lo: 13, aec: 1'b0, exp_ht: 3,  exp_gate_low: 0};
        vecs[3] = '{hi: 4,  lo: 12, aec: 1'b0, exp_ht: 4,  exp_gate_low: 1};
        vecs[4] = '{hi: 12, lo: 6,  aec: 1'b1, exp_ht: 12, exp_gate_low: 9};
        vecs[5] = '{hi: 5,  lo: 7,  aec: 1'b0, exp_ht: 5,  exp_gate_low: 2};
        vecs[6] = '{hi: 8,  lo: 8,  aec: 1'b1, exp_ht: 8,  exp_gate_low: 5};

        reset = 1'b1; phi0_in = 1'b0; aec_in = 1'b1;
        model_reset();
        clear_counts();
        repeat (3) step();
        check("reset_values", 32'(dut_outs()), 32'({1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0}));
        reset = 1'b0;

        // First accepted fall leaves SYNC silently
        clear_counts();
        drive_level(1'b1, 8);
        drive_level(1'b0, 8);
        check("sync_no_cycle_end", 32'(ce_cnt), 32'd0);
        check("sync_phi2_low", 32'(phi2_hi_cnt), 32'd0);

        foreach (vecs[i]) begin
            aec_in = vecs[i].aec;
            clear_counts();
            drive_level(1'b1, vecs[i].hi);
            drive_level(1'b0, vecs[i].lo);
            check($sformatf("vec%0d_high_ticks", i), 32'(high_ticks), 32'(vecs[i].exp_ht));
            check($sformatf("vec%0d_phi2_len", i), 32'(phi2_hi_cnt), 32'(vecs[i].hi));
            check($sformatf("vec%0d_gate_low", i), 32'(gate_low_cnt), 32'(vecs[i].exp_gate_low));
            check($sformatf("vec%0d_cycle_end", i), 32'(ce_cnt), 32'd1);
            check($sformatf("vec%0d_aec_out", i), 32'(aec_out), 32'(vecs[i].aec));
        end

        // One-tick glitch in the low phase
        clear_counts();
        drive_level(1'b0, 4);
        drive_level(1'b1, 1);
        drive_level(1'b0, 12);
        check("glitch_phi2", 32'(phi2_hi_cnt), 32'd0);
        check("glitch_cycle_end", 32'(ce_cnt), 32'd0);
        clear_counts();
        drive_level(1'b1, 8);
        drive_level(1'b0, 8);
        check("glitch_still_low_ce", 32'(ce_cnt), 32'd1);
        check("glitch_still_low_ht", 32'(high_ticks), 32'd8);

        // AEC capture only at the phi2 rise
        drive_level(1'b0, 4);
        aec_in = 1'b0;
        drive_level(1'b0, 4);
        drive_level(1'b1, 6);
        check("aec_drop_phi2", 32'(phi2), 32'd1);
        check("aec_drop", 32'(aec_out), 32'd0);
        aec_in = 1'b1;
        drive_level(1'b1, 2);
        drive_level(1'b0, 8);
        check("aec_hold", 32'(aec_out), 32'd0);
        drive_level(1'b1, 6);
        check("aec_next", 32'(aec_out), 32'd1);
        drive_level(1'b1, 2);
        drive_level(1'b0, 8);

        // Stall with phi0 stuck high
        rise_at = -1; fall_at = -1; gate_mid = -1; stall_pre = -1;
        phi0_in = 1'b1;
        for (int t = 0; t < 1100; t++) begin
            step();
            if (rise_at < 0 && phi2) begin
                rise_at   = t;
                stall_pre = stalled;
            end
            if (rise_at >= 0 && t == rise_at + 10) gate_mid = gate;
            if (rise_at >= 0 && fall_at < 0 && !phi2) fall_at = t;
        end
        check("stall_pre_flag", 32'(stall_pre), 32'd0);
        check("stall_in_held", 32'(gate_mid), 32'd0);
        check("stall_len", 32'(fall_at - rise_at), 32'(TO));
        check("stall_outs", 32'({phi2, gate, aec_out, stalled}), 32'(4'b0101));
        clear_counts();
        drive_level(1'b0, 8);
        check("resume_no_ce", 32'(ce_cnt), 32'd0);
        check("resume_sticky", 32'(stalled), 32'd1);
        clear_counts();
        drive_level(1'b1, 8);
        drive_level(1'b0, 8);
        check("resume_ht", 32'(high_ticks), 32'd8);
        check("resume_ce", 32'(ce_cnt), 32'd1);
        check("resume_still_sticky", 32'(stalled), 32'd1);

        // Reset two ticks into a high phase
        phi0_in = 1'b1;
        for (int t = 0; t < 20; t++) begin
            step();
            if (phi2) break;
        end
        check("rst_mid_phi2_up", 32'(phi2), 32'd1);
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_mid_outs", 32'(dut_outs()), 32'({1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0}));
        clear_counts();
        drive_level(1'b0, 8);
        check("rst_mid_sync_no_ce", 32'(ce_cnt), 32'd0);

        // Randomized periods, AEC levels, glitches and occasional resets
        for (int it = 0; it < 200; it++) begin
            aec_in = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
            end
            drive_level(1'b1, $urandom_range(1, 12));
            drive_level(1'b0, $urandom_range(1, 14));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/phi_sequencer.md
# phi_sequencer

Fast-clock bus-cycle sequencer that sits directly upstream of the 6502→7501 adapter. It samples the TED's asynchronous phi0 and AEC, then produces the glitch-free CPU clock, the R/W gate strobe and the AEC qualifier that drive the adapter's `clock`, `gate_in` and `aec` inputs. It also reports per-cycle timing and stall status for bring-up.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth for `phi0_in` and `aec_in`; legal values are ≥2.
- `FILTER`, 2: consecutive stable samples required before a synchronized `phi0` level is accepted; legal values are ≥1.
- `GATE_DELAY`, 3: ticks after `phi2` rises before `gate` falls; legal values are ≥1.
- `TIMEOUT`, 1024: ticks without an accepted `phi0` edge before the sequencer declares a stall.

- `clock`  in  1  fast system clock, at least 8× phi0.
- `reset`  in  1  synchronous, active-high.
- `phi0_in`  in  1  TED phi0, asynchronous.
- `aec_in`  in  1  TED AEC, asynchronous.
- `phi2`  out  1  CPU clock to the adapter. Registered; reset value 0.
- `gate`  out  1  R/W gate to the adapter's `gate_in`. Registered; reset value 1.
- `aec_out`  out  1  bus-enable qualifier to the adapter's `aec`. Registered; reset value 0.
- `cycle_end`  out  1  one-tick pulse on every accepted phi0 falling edge outside SYNC. Reset value 0.
- `high_ticks`  out  8  length of the last completed `phi2` high phase in ticks, saturating at 255. Reset value 0.
- `stalled`  out  1  sticky watchdog flag, cleared only by `reset`. Reset value 0.

## Operation
- **phi0 path.** `phi0_in` passes through a `SYNC_STAGES`-deep synchronizer and then the filter.
  - The filter holds the accepted level `pf`.
  - A counter increments while the synchronized level differs from `pf`. It clears whenever they match.
  - When the counter reaches `FILTER-1` and the levels still differ, `pf` takes the new level on the next tick and the counter clears.
  - Accepted rise and fall are one-tick pulses derived from `pf`.
- **aec path.** `aec_in` is synchronized only; it is not filtered.
- **FSM states:** SYNC, LOW, HIGH_GATED, HIGH_HELD.
- **SYNC.** Outputs `phi2`=0, `gate`=1, `aec_out`=0. On an accepted fall, go to LOW. No `cycle_end` pulse is generated on this transition.
- **LOW.** Outputs `phi2`=0, `gate`=1. On an accepted rise:
  - go to HIGH_GATED;
  - set `phi2`=1;
  - load `aec_out` from the synchronized AEC, and hold it for the whole high phase;
  - clear the phase counter.
- **HIGH_GATED.** `phi2`=1, `gate`=1, and the phase counter increments.
  - When the counter equals `GATE_DELAY-1`, go to HIGH_HELD and set `gate`=0.
  - An accepted fall before that point goes to LOW and performs the fall actions below; `gate` never drops in that cycle.
- **HIGH_HELD.** `phi2`=1, `gate`=0, and the counter keeps incrementing. An accepted fall goes to LOW with the fall actions.
- **Fall actions:**
  - set `phi2`=0 and `gate`=1;
  - pulse `cycle_end`;
  - set `high_ticks` to the phase count + 1, saturating at 255.
- **Watchdog.**
  - The counter clears on every accepted edge and increments otherwise.
  - In any state except SYNC, reaching `TIMEOUT-1` forces SYNC with all SYNC output values and sets `stalled`=1.
  - The watchdog is inactive in SYNC.
- **Reset mid-cycle.** Reset takes effect on the next `clock` edge regardless of state. All outputs return to their reset values and the FSM enters SYNC. `phi2` may therefore truncate a high phase; this is accepted.
- **Simultaneous events.** Rise and fall cannot be accepted on the same tick because `pf` changes only once per tick. If a fall is accepted on the same tick that the gate count matches, the fall wins.

## Timing
- **Edge latency.** A `phi0_in` edge that the first synchronizer flop captures at tick 0 appears on `phi2` after `SYNC_STAGES + FILTER + 1` ticks. With defaults that is 5 ticks, identical for rising and falling edges.
- **gate.** `gate` falls exactly `GATE_DELAY` ticks after `phi2` rises, provided the high phase lasts longer than that. `gate` rises on the same tick that `phi2` falls.
- **aec_out.** `aec_out` changes only on the tick `phi2` rises, or on entry to SYNC.
- **Glitches.** A pulse on `phi0_in` shorter than `FILTER` ticks (after synchronization) is never seen on `phi2`.
- **cycle_end.** Coincident with the `phi2` falling tick.

## Structure
- **Shared package `fake7501_pkg`:**
  - the state enum `seq_state_t` (SYNC, LOW, HIGH_GATED, HIGH_HELD);
  - default constants `SEQ_SYNC_STAGES`, `SEQ_FILTER`, `SEQ_GATE_DELAY`, `SEQ_TIMEOUT`.
- **Sub-module `phi_filter`:** synchronizer plus glitch filter, with parameters `SYNC_STAGES` and `FILTER`. It outputs `pf`, `rise` and `fall`. The top level instantiates it once, for phi0.
- Everything else lives in `phi_sequencer`.

## Test plan
All scenarios use default parameters.

1. **Clean clock.** After reset, drive `phi0_in` with a 16-tick period (8 high, 8 low) starting high.
   - The first fall enters LOW with no `cycle_end`.
   - Thereafter `phi2` has period 16 and lags `phi0_in` by 5 ticks.
   - `gate` is low for 5 of every 8 high ticks.
   - `high_ticks` reads 8 and `cycle_end` fires once per period.
2. **Glitch rejection.** Insert a 1-tick high pulse on `phi0_in` mid-low-phase → `phi2` is unchanged and the FSM stays in LOW.
3. **Short high phase.** Drive `phi0_in` with 2 high ticks and 14 low.
   - `phi2` is high for 2 ticks and `gate` never drops.
   - `high_ticks` reads 2.
4. **AEC capture.**
   - Drop `aec_in` mid-low-phase → `aec_out` goes to 0 at the next `phi2` rise.
   - Raise `aec_in` during a high phase → `aec_out` stays 0 until the following rise.
5. **Stall.** Hold `phi0_in` high for 1100 ticks while in HIGH_HELD.
   - At 1024 ticks: `phi2`=0, `gate`=1, `aec_out`=0, and `stalled`=1.
   - When clocking resumes, the first fall re-enters LOW and `stalled` stays 1.
6. **Reset mid-cycle.** Assert `reset` for 1 tick 2 ticks after `phi2` rises → the next tick shows every output at its reset value and the FSM in SYNC.
